pin_capture: RTL

//  Receive-side counterpart of the per-pin PWM generator: measures a square wave arriving on one

---
 rtl/pin_capture_pkg.sv | 34 +++
 rtl/pin_sync_edge.sv | 27 ++
 rtl/pin_capture.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pin_capture_pkg.sv
// Shared definitions for the pin capture block: register offsets, run code,
// status bit positions and the capture FSM state type.
package pin_capture_pkg;

  localparam int REG_GLOBAL_CMD = 0;
  localparam int OFS_CYCLES      = 4;
  localparam int OFS_TIMEOUT     = 8;
  localparam int OFS_HIGH_TIME   = 12;
  localparam int OFS_LOW_TIME    = 16;
  localparam int OFS_CYCLES_DONE = 20;
  localparam int OFS_STATUS      = 24;

  localparam logic [15:0] CMD_RUN = 16'd1;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_TIMEOUT  = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_LEVEL    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_RISE,
    S_HIGH,
    S_LOW,
    S_DONE
  } cap_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus one-clock rise/fall pulses.
// Both edges see the same latency, so it drops out of any interval measurement.
module pin_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pin_async,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0] metastability flop, [1] synced level, [2] previous synced level
  logic [2:0] sh_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_reg <= '0;
    end else begin
      sh_reg <= {sh_reg[1:0], pin_async};
    end
  end

  assign level = sh_reg[1];
  assign rise  = sh_reg[1] & ~sh_reg[2];
  assign fall  = ~sh_reg[1] & sh_reg[2];

endmodule

// File: rtl/pin_capture.sv
// Square-wave capture on one input pin: measures high time, low time and completed
// cycles in clk ticks, exposed on the shared addr/data register bus.
module pin_capture
  import pin_capture_pkg::*;
#(
  parameter int POSITION = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic        pin_input
);

  localparam logic [20:0] A_CMD         = 21'(REG_GLOBAL_CMD);
  localparam logic [20:0] A_CYCLES      = 21'(POSITION + OFS_CYCLES);
  localparam logic [20:0] A_TIMEOUT     = 21'(POSITION + OFS_TIMEOUT);
  localparam logic [20:0] A_HIGH_TIME   = 21'(POSITION + OFS_HIGH_TIME);
  localparam logic [20:0] A_LOW_TIME    = 21'(POSITION + OFS_LOW_TIME);
  localparam logic [20:0] A_CYCLES_DONE = 21'(POSITION + OFS_CYCLES_DONE);
  localparam logic [20:0] A_STATUS      = 21'(POSITION + OFS_STATUS);

  logic level, rise, fall, edge_seen;

  pin_sync_edge u_sync (
    .clk       (clk),
    .reset     (reset),
    .pin_async (pin_input),
    .level     (level),
    .rise      (rise),
    .fall      (fall)
  );

  cap_state_t  state_reg, state_next;
  logic [15:0] cmd_reg, cycles_reg, timeout_reg;
  logic [15:0] high_time_reg, high_time_next, low_time_reg, low_time_next;
  logic [15:0] cycles_done_reg, cycles_done_next, cycles_done_inc;
  logic [15:0] hi_cnt_reg, hi_cnt_next, lo_cnt_reg, lo_cnt_next, tick_reg, tick_next;
  logic        done_flag_reg, done_flag_next, timeout_flag_reg, timeout_flag_next;
  logic        overflow_reg, overflow_next;
  logic        run, busy, tmo_hit, go_timeout;
  logic [15:0] status, read_next;

  assign run             = (cmd_reg == CMD_RUN);
  assign busy            = state_reg inside {S_ARM, S_WAIT_RISE, S_HIGH, S_LOW};
  assign edge_seen       = rise | fall;
  // An edge in the same clock as the timeout always takes precedence.
  assign tmo_hit         = (timeout_reg != 16'd0) && (tick_reg >= timeout_reg) && !edge_seen;
  assign cycles_done_inc = cycles_done_reg + 16'd1;

  always_comb begin
    state_next        = state_reg;
    high_time_next    = high_time_reg;
    low_time_next     = low_time_reg;
    cycles_done_next  = cycles_done_reg;
    hi_cnt_next       = hi_cnt_reg;
    lo_cnt_next       = lo_cnt_reg;
    done_flag_next    = done_flag_reg;
    timeout_flag_next = timeout_flag_reg;
    overflow_next     = overflow_reg;
    go_timeout        = 1'b0;
    tick_next         = (busy && !edge_seen) ? sat_inc(tick_reg) : 16'd0;

    unique case (state_reg)
      S_IDLE: begin
        if (run) begin
          state_next        = S_ARM;
          high_time_next    = '0;
          low_time_next     = '0;
          cycles_done_next  = '0;
          done_flag_next    = 1'b0;
          timeout_flag_next = 1'b0;
          overflow_next     = 1'b0;
        end
      end
      S_ARM: begin
        if (!run)        state_next = S_IDLE;
        else if (!level) state_next = S_WAIT_RISE;
        else             go_timeout = tmo_hit;
      end
      S_WAIT_RISE: begin
        if (!run) begin
          state_next = S_IDLE;
        end else if (rise) begin
          state_next  = S_HIGH;
          hi_cnt_next = 16'd1;
        end else begin
          go_timeout = tmo_hit;
        end
      end
      S_HIGH: begin
        if (!run) begin
          state_next = S_IDLE;
        end else if (fall) begin
          state_next     = S_LOW;
          high_time_next = hi_cnt_reg;
          lo_cnt_next    = 16'd1;
        end else begin
          hi_cnt_next = sat_inc(hi_cnt_reg);
          if (hi_cnt_reg == 16'hFFFF) overflow_next = 1'b1;
          go_timeout = tmo_hit;
        end
      end
      S_LOW: begin
        if (!run) begin
          state_next = S_IDLE;
        end else if (rise) begin
          low_time_next    = lo_cnt_reg;
          cycles_done_next = cycles_done_inc;
          hi_cnt_next      = 16'd1;
          if (cycles_reg != 16'd0 && cycles_done_inc == cycles_reg) begin
            state_next     = S_DONE;
            done_flag_next = 1'b1;
          end else begin
            state_next = S_HIGH;
          end
        end else begin
          lo_cnt_next = sat_inc(lo_cnt_reg);
          if (lo_cnt_reg == 16'hFFFF) overflow_next = 1'b1;
          go_timeout = tmo_hit;
        end
      end
      S_DONE: begin
        if (!run) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (go_timeout) begin
      state_next        = S_DONE;
      done_flag_next    = 1'b1;
      timeout_flag_next = 1'b1;
    end
  end

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = busy;
    status[ST_DONE]     = done_flag_reg;
    status[ST_TIMEOUT]  = timeout_flag_reg;
    status[ST_OVERFLOW] = overflow_reg;
    status[ST_LEVEL]    = level;

    read_next = '0;
    if (addr == A_HIGH_TIME)        read_next = high_time_reg;
    else if (addr == A_LOW_TIME)    read_next = low_time_reg;
    else if (addr == A_CYCLES_DONE) read_next = cycles_done_reg;
    else if (addr == A_STATUS)      read_next = status;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      cmd_reg          <= '0;
      cycles_reg       <= '0;
      timeout_reg      <= '0;
      high_time_reg    <= '0;
      low_time_reg     <= '0;
      cycles_done_reg  <= '0;
      hi_cnt_reg       <= '0;
      lo_cnt_reg       <= '0;
      tick_reg         <= '0;
      done_flag_reg    <= 1'b0;
      timeout_flag_reg <= 1'b0;
      overflow_reg     <= 1'b0;
      data_out         <= '0;
    end else begin
      state_reg        <= state_next;
      high_time_reg    <= high_time_next;
      low_time_reg     <= low_time_next;
      cycles_done_reg  <= cycles_done_next;
      hi_cnt_reg       <= hi_cnt_next;
      lo_cnt_reg       <= lo_cnt_next;
      tick_reg         <= tick_next;
      done_flag_reg    <= done_flag_next;
      timeout_flag_reg <= timeout_flag_next;
      overflow_reg     <= overflow_next;
      data_out         <= read_next;
      // The bus has no strobe: a matching address is a write.
      if (addr == A_CMD)     cmd_reg     <= data_in;
      if (addr == A_CYCLES)  cycles_reg  <= data_in;
      if (addr == A_TIMEOUT) timeout_reg <= data_in;
    end
  end

endmodule
